// File: rtl/sprite_bram_loader_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sprite_bram_loader_if: pixel-stream and BRAM-write bundle for loader |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
interface sprite_bram_loader_if;
  logic        start;
  logic [2:0]  sprite_idx;
  logic        abort;
  logic        pix_valid;
  logic        pix_ready;
  logic [2:0]  pixel_in;
  logic        bram_we;
  logic [4:0]  bram_index;
  logic [7:0]  bram_addr;
  logic [15:0] bram_wdata;
  logic        busy;
  logic        done;
  logic        err;

  modport slave (
    input  start, sprite_idx, abort, pix_valid, pixel_in,
    output pix_ready, bram_we, bram_index, bram_addr, bram_wdata, busy, done, err
  );

  modport master (
    output start, sprite_idx, abort, pix_valid, pixel_in,
    input  pix_ready, bram_we, bram_index, bram_addr, bram_wdata, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/sprite_bram_loader.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sprite_bram_loader: packs 5 RGB pixels per word into sprite BRAMs     |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module sprite_bram_loader #(
  parameter int unsigned NUM_SPRITES   = 7,
  parameter int unsigned SPRITE_PIXELS = 4096,
  parameter int unsigned PIX_PER_WORD  = 5
) (
  input  wire logic clk,
  input  wire logic reset,
  sprite_bram_loader_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [11:0] c_last_pix  = 12'(SPRITE_PIXELS - 1);
  localparam logic [2:0]  c_last_slot = 3'(PIX_PER_WORD - 1);
  localparam logic [3:0]  c_num_spr   = 4'(NUM_SPRITES);

  state_t      state_q, state_d;
  logic [2:0]  sprite_q, sprite_d;
  logic [11:0] pix_cnt_q, pix_cnt_d;
  logic [2:0]  slot_q, slot_d;
  logic [9:0]  word_q, word_d;
  logic [15:0] pack_q, pack_d;
  logic        we_q, we_d;
  logic [4:0]  index_q, index_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        err_q, err_d;

  logic        accept;
  logic        last_pix;
  logic        emit;
  logic [15:0] merged;
  logic        pix_ready;
  logic        busy;
  logic        done;

  assign accept   = (state_q == S_LOAD) && bus.pix_valid && !bus.abort;
  assign last_pix = (pix_cnt_q == c_last_pix);
  assign emit     = accept && ((slot_q == c_last_slot) || last_pix);

  // Current pack with the incoming pixel dropped into its slot.
  always_comb begin
    merged = pack_q;
    case (slot_q)
      3'd0:    merged[2:0]   = bus.pixel_in;
      3'd1:    merged[5:3]   = bus.pixel_in;
      3'd2:    merged[8:6]   = bus.pixel_in;
      3'd3:    merged[11:9]  = bus.pixel_in;
      3'd4:    merged[14:12] = bus.pixel_in;
      default: merged        = pack_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    sprite_d  = sprite_q;
    pix_cnt_d = pix_cnt_q;
    slot_d    = slot_q;
    word_d    = word_q;
    pack_d    = pack_q;
    we_d      = 1'b0;
    index_d   = index_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = 1'b0;
    pix_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if ({1'b0, bus.sprite_idx} < c_num_spr) begin
            sprite_d  = bus.sprite_idx;
            pix_cnt_d = '0;
            slot_d    = '0;
            word_d    = '0;
            pack_d    = '0;
            state_d   = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_LOAD: begin
        pix_ready = 1'b1;
        busy      = 1'b1;
        if (bus.abort) begin
          pack_d  = '0;
          state_d = S_IDLE;
        end else if (accept) begin
          pix_cnt_d = pix_cnt_q + 12'd1;
          if (emit) begin
            // Word leaves through the output register; pack restarts empty.
            we_d    = 1'b1;
            index_d = {sprite_q, word_q[9:8]};
            addr_d  = word_q[7:0];
            wdata_d = merged;
            pack_d  = '0;
            slot_d  = '0;
            word_d  = word_q + 10'd1;
          end else begin
            pack_d = merged;
            slot_d = slot_q + 3'd1;
          end
          if (last_pix) begin
            state_d = S_FLUSH;
          end
        end
      end

      S_FLUSH: begin
        busy    = 1'b1;
        state_d = bus.abort ? S_IDLE : S_DONE;
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sprite_q  <= '0;
      pix_cnt_q <= '0;
      slot_q    <= '0;
      word_q    <= '0;
      pack_q    <= '0;
      we_q      <= 1'b0;
      index_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sprite_q  <= sprite_d;
      pix_cnt_q <= pix_cnt_d;
      slot_q    <= slot_d;
      word_q    <= word_d;
      pack_q    <= pack_d;
      we_q      <= we_d;
      index_q   <= index_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
    end
  end

  assign bus.pix_ready  = pix_ready;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.err        = err_q;
  assign bus.bram_we    = we_q;
  assign bus.bram_index = index_q;
  assign bus.bram_addr  = addr_q;
  assign bus.bram_wdata = wdata_q;

endmodule
`default_nettype wire
